// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock via a WIDTH+1-bit
// trial subtraction whose sign bit selects restore or keep.
module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;
  logic             dz;

  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   nr;
  logic [WIDTH-1:0] nq;

  // One iteration: shift next dividend bit into R, trial-subtract, restore if negative.
  always_comb begin
    sh = {r[WIDTH-1:0], q[WIDTH-1]};
    t  = sh + ~{1'b0, dsr} + ONE;
    nr = t;
    nq = {q[WIDTH-2:0], 1'b1};
    if (t[WIDTH]) begin
      nr = sh;
      nq = {q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      r           <= '0;
      q           <= '0;
      dsr         <= '0;
      cnt         <= '0;
      dz          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            // A zero divisor passes through RUN for one idle cycle so done lands one edge later.
            dsr         <= divisor;
            q           <= dividend;
            r           <= '0;
            cnt         <= '0;
            dz          <= (divisor == '0);
            busy        <= (divisor != '0);
            div_by_zero <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (dz) begin
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= q;
            div_by_zero <= 1'b1;
          end else begin
            r   <= nr;
            q   <= nq;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              quotient  <= nq;
              remainder <= nr[WIDTH-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: a 32-bit and an 8-bit instance driven with
// directed vectors; monitors check results, latency, busy length and single-cycle done.
module tb_seq_restoring_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
    int          bsy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start8;
  logic [31:0] dividend, divisor;
  logic [7:0]  dividend8, divisor8;
  logic        busy, done, dz, busy8, done8, dz8;
  logic [31:0] quotient, remainder;
  logic [7:0]  quotient8, remainder8;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bc = 0, bc8 = 0;
  logic pdone = 1'b0, pdone8 = 1'b0;
  exp_t sb[$];
  exp_t sb8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_restoring_divider #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(dz)
  );

  seq_restoring_divider #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(dz8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 32-bit monitor
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      chk("done_pulse_width", {31'b0, pdone}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'b0, dz}, {31'b0, e.dz});
        chk("latency", cyc, e.cyc);
        chk("busy_cycles", bc, e.bsy);
      end
      bc = 0;
    end else if (busy) bc++;
    else bc = 0;
    pdone = done;
  end

  // 8-bit monitor
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      chk("done8_pulse_width", {31'b0, pdone8}, 32'd0);
      if (sb8.size() == 0) begin
        chk("unexpected_done8", 32'd1, 32'd0);
      end else begin
        e = sb8.pop_front();
        chk("quotient8", {24'b0, quotient8}, e.q);
        chk("remainder8", {24'b0, remainder8}, e.r);
        chk("div_by_zero8", {31'b0, dz8}, {31'b0, e.dz});
        chk("latency8", cyc, e.cyc);
        chk("busy8_cycles", bc8, e.bsy);
      end
      bc8 = 0;
    end else if (busy8) bc8++;
    else bc8 = 0;
    pdone8 = done8;
  end

  // Called at a negedge; the start is accepted on the following posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic push,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz);
    exp_t e;
    start = 1'b1; dividend = a; divisor = b;
    if (push) begin
      e.q = eq; e.r = er; e.dz = edz;
      e.cyc = cyc + 1 + ((b == 0) ? 1 : 32);
      e.bsy = (b == 0) ? 0 : 32;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz);
    exp_t e;
    start8 = 1'b1; dividend8 = a; divisor8 = b;
    e.q = {24'b0, eq}; e.r = {24'b0, er}; e.dz = edz;
    e.cyc = cyc + 1 + ((b == 0) ? 1 : 8);
    e.bsy = (b == 0) ? 0 : 8;
    sb8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_done8(input string name);
    int n = 0;
    while (!done8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done8) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic div32(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz);
    @(negedge clk);
    issue(a, b, 1'b1, eq, er, edz);
    wait_done("div32");
  endtask

  task automatic div8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er, input logic edz);
    @(negedge clk);
    issue8(a, b, eq, er, edz);
    wait_done8("div8");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    dividend = '0; divisor = '0; dividend8 = '0; divisor8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dz", {31'b0, dz}, 32'd0);
    rst = 1'b0;

    div32(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    div32(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    div32(32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
    div32(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    div32(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    div32(32'd1000000, 32'd1000, 32'd1000, 32'd0, 1'b0);
    div32(32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF, 1'b0);
    div32(32'd12345, 32'd12345, 32'd1, 32'd0, 1'b0);
    div32(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted back-to-back.
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
    repeat (5) @(negedge clk);
    issue(32'd9, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
    wait_done("b2b_first");
    issue(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0);
    wait_done("b2b_second");

    // Reset mid-divide aborts without a done pulse.
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    repeat (40) @(negedge clk);
    div32(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    div8(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    div8(8'd255, 8'd16, 8'd15, 8'd15, 1'b0);
    div8(8'd13, 8'd200, 8'd0, 8'd13, 1'b0);
    div8(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    div8(8'd9, 8'd0, 8'hFF, 8'd9, 1'b1);
    div8(8'd128, 8'd3, 8'd42, 8'd2, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    chk("sb8_drained", sb8.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
